rv32i_pipeline_controller: RTL and testbench



---
 rtl/rv32i_pipeline_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_rv32i_pipeline_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipeline_controller.sv
// Control path for a 5-stage RV32I pipeline (F, D, E, M, WB) without forwarding.
// Decodes the D-stage instruction, carries control in valid-tagged E/M/WB
// registers, stalls on RAW hazards, resolves jumps in D and branches in E.
// Handshake: there is none; every register advances each cycle, and a stall or
// squash turns the instruction entering E into a bubble (valid=0).
module rv32i_pipeline_controller (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic        alu_zero_i,
  input  logic        alu_lt_i,
  output logic        stall_o,
  output logic        pip_jump_o,
  output logic        branch_taken_o,
  output logic [2:0]  pc_next_sel_o,
  output logic [1:0]  alu_src1_o,
  output logic        alu_src2_o,
  output logic [2:0]  imm_gen_sel_o,
  output logic [3:0]  alu_control_o,
  output logic        dmem_we_o,
  output logic        reg_we_o,
  output logic [1:0]  wb_sel_o,
  output logic [4:0]  rd_add_o,
  output logic        illegal_o
);

  // Encodings shared with the datapath (mirrors RV32i_pkg).
  localparam logic [2:0] SEL_PC_PLUS_4 = 3'd0;
  localparam logic [2:0] SEL_PC_BRANCH = 3'd1;
  localparam logic [2:0] SEL_PC_JAL    = 3'd2;
  localparam logic [2:0] SEL_PC_JALR   = 3'd3;
  localparam logic [1:0] SEL_OP1_RS1   = 2'd0;
  localparam logic [1:0] SEL_OP1_PC    = 2'd1;
  localparam logic [1:0] SEL_OP1_ZERO  = 2'd2;
  localparam logic       SEL_OP2_RS2   = 1'b0;
  localparam logic       SEL_OP2_IMM   = 1'b1;
  localparam logic [2:0] IMMI = 3'd0;
  localparam logic [2:0] IMMS = 3'd1;
  localparam logic [2:0] IMMB = 3'd2;
  localparam logic [2:0] IMMU = 3'd3;
  localparam logic [2:0] IMMJ = 3'd4;
  localparam logic [1:0] SEL_WB_ALU       = 2'd0;
  localparam logic [1:0] SEL_WB_MEM       = 2'd1;
  localparam logic [1:0] SEL_WB_PC_PLUS_4 = 2'd2;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       mem_write;
  } stage_t;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = instruction_i[6:0];
  assign func3  = instruction_i[14:12];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];
  assign rd     = instruction_i[11:7];

  logic       d_valid, uses_rs1, uses_rs2, d_reg_we, d_mem_write;
  logic       d_is_branch, d_is_jal, d_is_jalr;
  logic [1:0] d_wb_sel;
  logic [3:0] d_alu;

  stage_t     e_q, m_q, wb_q;
  logic [3:0] e_alu_q;
  logic       e_is_branch_q;
  logic [2:0] e_func3_q;

  logic stall_raw, branch_cond, take_branch, load_e;

  // ALU function for OP / OP-IMM; alt (bit 30) selects SUB only for register OP.
  function automatic logic [3:0] arith_fn(input logic [2:0] f3, input logic alt,
                                          input logic is_reg_op);
    case (f3)
      3'b000:  arith_fn = (alt && is_reg_op) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_fn = ALU_SLL;
      3'b010:  arith_fn = ALU_SLT;
      3'b011:  arith_fn = ALU_SLTU;
      3'b100:  arith_fn = ALU_XOR;
      3'b101:  arith_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_fn = ALU_OR;
      default: arith_fn = ALU_AND;
    endcase
  endfunction

  // D-stage decode; unsupported opcodes (including the all-zero bubble) leave d_valid low.
  always_comb begin
    d_valid       = 1'b1;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    d_reg_we      = 1'b0;
    d_mem_write   = 1'b0;
    d_is_branch   = 1'b0;
    d_is_jal      = 1'b0;
    d_is_jalr     = 1'b0;
    d_wb_sel      = SEL_WB_ALU;
    d_alu         = ALU_ADD;
    alu_src1_o    = SEL_OP1_RS1;
    alu_src2_o    = SEL_OP2_IMM;
    imm_gen_sel_o = IMMI;
    case (opcode)
      7'b0110111: begin // LUI
        alu_src1_o = SEL_OP1_ZERO; imm_gen_sel_o = IMMU; d_reg_we = 1'b1;
      end
      7'b0010111: begin // AUIPC
        alu_src1_o = SEL_OP1_PC; imm_gen_sel_o = IMMU; d_reg_we = 1'b1;
      end
      7'b1101111: begin // JAL
        alu_src1_o = SEL_OP1_PC; imm_gen_sel_o = IMMJ; d_reg_we = 1'b1;
        d_wb_sel = SEL_WB_PC_PLUS_4; d_is_jal = 1'b1;
      end
      7'b1100111: begin // JALR
        uses_rs1 = 1'b1; d_reg_we = 1'b1;
        d_wb_sel = SEL_WB_PC_PLUS_4; d_is_jalr = 1'b1;
      end
      7'b1100011: begin // BRANCH: compare via ALU, flags consumed in E
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_src2_o = SEL_OP2_RS2;
        imm_gen_sel_o = IMMB; d_is_branch = 1'b1;
        case (func3[2:1])
          2'b10:   d_alu = ALU_SLT;
          2'b11:   d_alu = ALU_SLTU;
          default: d_alu = ALU_SUB;
        endcase
      end
      7'b0000011: begin // LOAD
        uses_rs1 = 1'b1; d_reg_we = 1'b1; d_wb_sel = SEL_WB_MEM;
      end
      7'b0100011: begin // STORE
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_gen_sel_o = IMMS; d_mem_write = 1'b1;
      end
      7'b0010011: begin // OP-IMM
        uses_rs1 = 1'b1; d_reg_we = 1'b1;
        d_alu = arith_fn(func3, instruction_i[30], 1'b0);
      end
      7'b0110011: begin // OP
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; alu_src2_o = SEL_OP2_RS2; d_reg_we = 1'b1;
        d_alu = arith_fn(func3, instruction_i[30], 1'b1);
      end
      default: d_valid = 1'b0;
    endcase
  end

  // RAW hazard against any in-flight writer; WB counts since the regfile is not write-through.
  always_comb begin
    stall_raw = 1'b0;
    if (d_valid) begin
      if (uses_rs1 && rs1 != 5'd0 &&
          ((e_q.valid && e_q.reg_we && e_q.rd == rs1) ||
           (m_q.valid && m_q.reg_we && m_q.rd == rs1) ||
           (wb_q.valid && wb_q.reg_we && wb_q.rd == rs1)))
        stall_raw = 1'b1;
      if (uses_rs2 && rs2 != 5'd0 &&
          ((e_q.valid && e_q.reg_we && e_q.rd == rs2) ||
           (m_q.valid && m_q.reg_we && m_q.rd == rs2) ||
           (wb_q.valid && wb_q.reg_we && wb_q.rd == rs2)))
        stall_raw = 1'b1;
    end
  end

  // Branch condition from the E-stage func3 and ALU flags.
  always_comb begin
    case (e_func3_q)
      3'b000:         branch_cond = alu_zero_i;
      3'b001:         branch_cond = !alu_zero_i;
      3'b100, 3'b110: branch_cond = alu_lt_i;
      3'b101, 3'b111: branch_cond = !alu_lt_i;
      default:        branch_cond = 1'b0;
    endcase
  end

  assign take_branch = e_q.valid && e_is_branch_q && branch_cond;
  assign load_e      = d_valid && !stall_raw && !take_branch;

  // Decision outputs; a taken branch makes the D instruction wrong-path and silences it.
  always_comb begin
    branch_taken_o = take_branch;
    stall_o        = stall_raw && !take_branch;
    pip_jump_o     = d_valid && (d_is_jal || d_is_jalr) && !stall_raw && !take_branch;
    illegal_o      = !d_valid && (instruction_i != 32'd0) && !take_branch;
    if (take_branch)    pc_next_sel_o = SEL_PC_BRANCH;
    else if (stall_raw) pc_next_sel_o = SEL_PC_PLUS_4;
    else if (pip_jump_o) pc_next_sel_o = d_is_jal ? SEL_PC_JAL : SEL_PC_JALR;
    else                pc_next_sel_o = SEL_PC_PLUS_4;
  end

  // Stage registers: E loads D or a bubble, M and WB shift every cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e_q           <= '0;
      m_q           <= '0;
      wb_q          <= '0;
      e_alu_q       <= ALU_ADD;
      e_is_branch_q <= 1'b0;
      e_func3_q     <= 3'd0;
    end else begin
      if (load_e) begin
        e_q.valid     <= 1'b1;
        e_q.rd        <= rd;
        e_q.reg_we    <= d_reg_we;
        e_q.wb_sel    <= d_wb_sel;
        e_q.mem_write <= d_mem_write;
        e_alu_q       <= d_alu;
        e_is_branch_q <= d_is_branch;
        e_func3_q     <= func3;
      end else begin
        e_q           <= '0;
        e_alu_q       <= ALU_ADD;
        e_is_branch_q <= 1'b0;
        e_func3_q     <= 3'd0;
      end
      m_q  <= e_q;
      wb_q <= m_q;
    end
  end

  // Staged outputs to the datapath.
  always_comb begin
    alu_control_o = e_q.valid ? e_alu_q : ALU_ADD;
    dmem_we_o     = m_q.valid && m_q.mem_write;
    reg_we_o      = wb_q.valid && wb_q.reg_we && (wb_q.rd != 5'd0);
    wb_sel_o      = wb_q.wb_sel;
    rd_add_o      = wb_q.rd;
  end

endmodule

// File: tb/tb_rv32i_pipeline_controller.sv
// Directed bench for rv32i_pipeline_controller: stage timing, RAW stalls,
// branches, jumps, stores/loads, illegal opcodes and reset.
module tb_rv32i_pipeline_controller;

  localparam logic [2:0] PC4 = 3'd0, PCBR = 3'd1, PCJAL = 3'd2, PCJALR = 3'd3;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLT = 4'd3;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd4;

  localparam logic [31:0] ADDI_X1_5 = 32'h00500093;
  localparam logic [31:0] ADDI_X3_1 = 32'h00100193;
  localparam logic [31:0] ADDI_X5_8 = 32'h00800293;
  localparam logic [31:0] ADD_X2    = 32'h00108133;
  localparam logic [31:0] SUB_X5    = 32'h402082B3;
  localparam logic [31:0] BEQ       = 32'h00000463;
  localparam logic [31:0] BLT       = 32'h00004463;
  localparam logic [31:0] JAL_X1    = 32'h010000EF;
  localparam logic [31:0] JALR_X1   = 32'h000280E7;
  localparam logic [31:0] SW        = 32'h0010A023;
  localparam logic [31:0] LW_X6     = 32'h00002303;

  logic        clk, reset_i, alu_zero_i, alu_lt_i;
  logic [31:0] instruction_i;
  logic        stall_o, pip_jump_o, branch_taken_o, alu_src2_o;
  logic [2:0]  pc_next_sel_o, imm_gen_sel_o;
  logic [1:0]  alu_src1_o, wb_sel_o;
  logic [3:0]  alu_control_o;
  logic        dmem_we_o, reg_we_o, illegal_o;
  logic [4:0]  rd_add_o;

  int errors = 0;
  int checks = 0;

  rv32i_pipeline_controller dut (
    .clk_i(clk), .reset_i(reset_i), .instruction_i(instruction_i),
    .alu_zero_i(alu_zero_i), .alu_lt_i(alu_lt_i),
    .stall_o(stall_o), .pip_jump_o(pip_jump_o), .branch_taken_o(branch_taken_o),
    .pc_next_sel_o(pc_next_sel_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .imm_gen_sel_o(imm_gen_sel_o), .alu_control_o(alu_control_o),
    .dmem_we_o(dmem_we_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
    .rd_add_o(rd_add_o), .illegal_o(illegal_o)
  );

  // Clock and initial input values
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset_i = 1'b1; instruction_i = '0; alu_zero_i = 1'b0; alu_lt_i = 1'b0;
  end

  // Present one D-stage instruction for a cycle; returns mid-cycle with outputs settled.
  task automatic cyc(input logic [31:0] ins, input logic z, input logic lt);
    @(posedge clk); #1;
    instruction_i = ins; alu_zero_i = z; alu_lt_i = lt;
    #4;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_i = 1'b1; instruction_i = '0; alu_zero_i = 1'b0; alu_lt_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_i = 1'b0;
    #4;
  endtask

  task automatic drain();
    repeat (4) cyc(32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall_o); end
    checks++; if (pip_jump_o !== 1'b0) begin errors++; $display("FAIL rst_jump got=%0h exp=0", pip_jump_o); end
    checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL rst_branch got=%0h exp=0", branch_taken_o); end
    checks++; if (pc_next_sel_o !== PC4) begin errors++; $display("FAIL rst_pcsel got=%0h exp=%0h", pc_next_sel_o, PC4); end
    checks++; if (alu_control_o !== A_ADD) begin errors++; $display("FAIL rst_alu got=%0h exp=%0h", alu_control_o, A_ADD); end
    checks++; if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL rst_dmem got=%0h exp=0", dmem_we_o); end
    checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL rst_regwe got=%0h exp=0", reg_we_o); end
    checks++; if (wb_sel_o !== WB_ALU) begin errors++; $display("FAIL rst_wbsel got=%0h exp=%0h", wb_sel_o, WB_ALU); end
    checks++; if (rd_add_o !== 5'd0) begin errors++; $display("FAIL rst_rd got=%0h exp=0", rd_add_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%0h exp=0", illegal_o); end
    for (int i = 0; i < 4; i++) begin
      cyc(32'd0, 1'b0, 1'b0);
      checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL rst_idle_regwe cyc=%0d got=%0h exp=0", i, reg_we_o); end
    end
  endtask

  task automatic test_back_to_back();
    cyc(ADDI_X1_5, 1'b0, 1'b0); // n
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_n got=%0h exp=0", stall_o); end
    checks++; if (alu_src2_o !== 1'b1 || imm_gen_sel_o !== IMM_I) begin errors++; $display("FAIL b2b_addi_sel got=%0h/%0h exp=1/%0h", alu_src2_o, imm_gen_sel_o, IMM_I); end
    for (int k = 1; k <= 3; k++) begin
      cyc(ADD_X2, 1'b0, 1'b0);
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_stall n+%0d got=%0h exp=1", k, stall_o); end
    end
    checks++; if (reg_we_o !== 1'b1 || rd_add_o !== 5'd1) begin errors++; $display("FAIL b2b_wb1 got=%0h/%0d exp=1/1", reg_we_o, rd_add_o); end
    cyc(ADD_X2, 1'b0, 1'b0); // n+4
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_n4 got=%0h exp=0", stall_o); end
    cyc(32'd0, 1'b0, 1'b0); // n+5
    cyc(32'd0, 1'b0, 1'b0); // n+6
    checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL b2b_n6_regwe got=%0h exp=0", reg_we_o); end
    cyc(32'd0, 1'b0, 1'b0); // n+7
    checks++; if (reg_we_o !== 1'b1 || rd_add_o !== 5'd2) begin errors++; $display("FAIL b2b_wb2 got=%0h/%0d exp=1/2", reg_we_o, rd_add_o); end
    drain();
  endtask

  task automatic test_gap_stall();
    cyc(ADDI_X1_5, 1'b0, 1'b0); // n
    cyc(ADDI_X3_1, 1'b0, 1'b0); // n+1 independent
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL gap_stall_n1 got=%0h exp=0", stall_o); end
    cyc(ADD_X2, 1'b0, 1'b0);    // n+2
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL gap_stall_n2 got=%0h exp=1", stall_o); end
    cyc(ADD_X2, 1'b0, 1'b0);    // n+3
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL gap_stall_n3 got=%0h exp=1", stall_o); end
    cyc(ADD_X2, 1'b0, 1'b0);    // n+4
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL gap_stall_n4 got=%0h exp=0", stall_o); end
    checks++; if (reg_we_o !== 1'b1 || rd_add_o !== 5'd3) begin errors++; $display("FAIL gap_wb3 got=%0h/%0d exp=1/3", reg_we_o, rd_add_o); end
    cyc(SUB_X5, 1'b0, 1'b0);    // independent of in-flight x2? no: x2 in E -> stalls
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL sub_stall got=%0h exp=1", stall_o); end
    drain();
    cyc(SUB_X5, 1'b0, 1'b0);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL sub_nostall got=%0h exp=0", stall_o); end
    cyc(32'd0, 1'b0, 1'b0);
    checks++; if (alu_control_o !== A_SUB) begin errors++; $display("FAIL sub_alu got=%0h exp=%0h", alu_control_o, A_SUB); end
    drain();
  endtask

  task automatic test_branch();
    cyc(BEQ, 1'b0, 1'b0); // n
    checks++; if (branch_taken_o !== 1'b0 || imm_gen_sel_o !== IMM_B || alu_src2_o !== 1'b0) begin errors++; $display("FAIL br_decode got=%0h/%0h/%0h exp=0/%0h/0", branch_taken_o, imm_gen_sel_o, alu_src2_o, IMM_B); end
    cyc(ADDI_X1_5, 1'b1, 1'b0); // n+1 wrong-path D
    checks++; if (branch_taken_o !== 1'b1 || pc_next_sel_o !== PCBR) begin errors++; $display("FAIL br_taken got=%0h/%0h exp=1/%0h", branch_taken_o, pc_next_sel_o, PCBR); end
    checks++; if (alu_control_o !== A_SUB) begin errors++; $display("FAIL br_alu got=%0h exp=%0h", alu_control_o, A_SUB); end
    cyc(32'd0, 1'b1, 1'b0); // n+2 squashed F
    checks++; if (branch_taken_o !== 1'b0 || pc_next_sel_o !== PC4) begin errors++; $display("FAIL br_oneshot got=%0h/%0h exp=0/%0h", branch_taken_o, pc_next_sel_o, PC4); end
    for (int i = 3; i <= 5; i++) begin
      cyc(32'd0, 1'b0, 1'b0);
      checks++; if (reg_we_o !== 1'b0) begin errors++; $display("FAIL br_squash_regwe n+%0d got=%0h exp=0", i, reg_we_o); end
    end
    drain();
    // not taken: no squash
    cyc(BEQ, 1'b0, 1'b0);
    cyc(ADDI_X3_1, 1'b0, 1'b0);
    checks++; if (branch_taken_o !== 1'b0 || pc_next_sel_o !== PC4) begin errors++; $display("FAIL br_nt got=%0h/%0h exp=0/%0h", branch_taken_o, pc_next_sel_o, PC4); end
    repeat (3) cyc(32'd0, 1'b0, 1'b0);
    checks++; if (reg_we_o !== 1'b1 || rd_add_o !== 5'd3) begin errors++; $display("FAIL br_nt_wb got=%0h/%0d exp=1/3", reg_we_o, rd_add_o); end
    drain();
    // BLT taken on lt
    cyc(BLT, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b1);
    checks++; if (branch_taken_o !== 1'b1 || alu_control_o !== A_SLT) begin errors++; $display("FAIL blt got=%0h/%0h exp=1/%0h", branch_taken_o, alu_control_o, A_SLT); end
    drain();
  endtask

  task automatic test_jump();
    cyc(JAL_X1, 1'b0, 1'b0); // n
    checks++; if (pip_jump_o !== 1'b1 || pc_next_sel_o !== PCJAL) begin errors++; $display("FAIL jal_jump got=%0h/%0h exp=1/%0h", pip_jump_o, pc_next_sel_o, PCJAL); end
    checks++; if (imm_gen_sel_o !== IMM_J) begin errors++; $display("FAIL jal_imm got=%0h exp=%0h", imm_gen_sel_o, IMM_J); end
    cyc(32'd0, 1'b0, 1'b0); // n+1
    checks++; if (pip_jump_o !== 1'b0) begin errors++; $display("FAIL jal_oneshot got=%0h exp=0", pip_jump_o); end
    cyc(32'd0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0); // n+3
    checks++; if (reg_we_o !== 1'b1 || rd_add_o !== 5'd1 || wb_sel_o !== WB_PC4) begin errors++; $display("FAIL jal_wb got=%0h/%0d/%0h exp=1/1/%0h", reg_we_o, rd_add_o, wb_sel_o, WB_PC4); end
    drain();
    // JALR waits for rs1 hazard to clear
    cyc(ADDI_X5_8, 1'b0, 1'b0); // n
    for (int k = 1; k <= 3; k++) begin
      cyc(JALR_X1, 1'b0, 1'b0);
      checks++; if (pip_jump_o !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL jalr_hold n+%0d got=%0h/%0h exp=0/1", k, pip_jump_o, stall_o); end
    end
    cyc(JALR_X1, 1'b0, 1'b0); // n+4
    checks++; if (pip_jump_o !== 1'b1 || pc_next_sel_o !== PCJALR) begin errors++; $display("FAIL jalr_go got=%0h/%0h exp=1/%0h", pip_jump_o, pc_next_sel_o, PCJALR); end
    drain();
  endtask

  task automatic test_simultaneous();
    cyc(ADDI_X5_8, 1'b0, 1'b0); // n
    cyc(BEQ, 1'b0, 1'b0);       // n+1
    cyc(JALR_X1, 1'b1, 1'b0);   // n+2: branch in E, x5 in M
    checks++; if (branch_taken_o !== 1'b1 || stall_o !== 1'b0 || pip_jump_o !== 1'b0) begin errors++; $display("FAIL simul got=%0h/%0h/%0h exp=1/0/0", branch_taken_o, stall_o, pip_jump_o); end
    checks++; if (pc_next_sel_o !== PCBR) begin errors++; $display("FAIL simul_pcsel got=%0h exp=%0h", pc_next_sel_o, PCBR); end
    drain();
  endtask

  task automatic test_store_load_illegal();
    cyc(SW, 1'b0, 1'b0); // n
    checks++; if (imm_gen_sel_o !== IMM_S || dmem_we_o !== 1'b0) begin errors++; $display("FAIL sw_n got=%0h/%0h exp=%0h/0", imm_gen_sel_o, dmem_we_o, IMM_S); end
    cyc(32'd0, 1'b0, 1'b0); // n+1
    checks++; if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL sw_n1 got=%0h exp=0", dmem_we_o); end
    cyc(32'd0, 1'b0, 1'b0); // n+2
    checks++; if (dmem_we_o !== 1'b1) begin errors++; $display("FAIL sw_n2 got=%0h exp=1", dmem_we_o); end
    cyc(32'd0, 1'b0, 1'b0); // n+3
    checks++; if (dmem_we_o !== 1'b0 || reg_we_o !== 1'b0) begin errors++; $display("FAIL sw_n3 got=%0h/%0h exp=0/0", dmem_we_o, reg_we_o); end
    drain();
    cyc(LW_X6, 1'b0, 1'b0);
    repeat (3) cyc(32'd0, 1'b0, 1'b0);
    checks++; if (reg_we_o !== 1'b1 || rd_add_o !== 5'd6 || wb_sel_o !== WB_MEM) begin errors++; $display("FAIL lw_wb got=%0h/%0d/%0h exp=1/6/%0h", reg_we_o, rd_add_o, wb_sel_o, WB_MEM); end
    drain();
    cyc(32'hFFFFFFFF, 1'b0, 1'b0);
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL ill_pulse got=%0h exp=1", illegal_o); end
    cyc(32'd0, 1'b0, 1'b0);
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL ill_oneshot got=%0h exp=0", illegal_o); end
    for (int i = 2; i <= 4; i++) begin
      cyc(32'd0, 1'b0, 1'b0);
      checks++; if (reg_we_o !== 1'b0 || dmem_we_o !== 1'b0) begin errors++; $display("FAIL ill_nowrite n+%0d got=%0h/%0h exp=0/0", i, reg_we_o, dmem_we_o); end
    end
  endtask

  task automatic test_reset_mid();
    cyc(ADDI_X1_5, 1'b0, 1'b0);
    cyc(SW, 1'b0, 1'b0);
    cyc(ADDI_X3_1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (reg_we_o !== 1'b0 || dmem_we_o !== 1'b0) begin errors++; $display("FAIL midrst_nowrite cyc=%0d got=%0h/%0h exp=0/0", i, reg_we_o, dmem_we_o); end
      cyc(32'd0, 1'b0, 1'b0);
    end
  endtask

  // Sequence of scenarios and final report
  initial begin
    test_reset();
    test_back_to_back();
    test_gap_stall();
    test_branch();
    test_jump();
    test_simultaneous();
    test_store_load_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
